event_led_counter: RTL and testbench
====================================

// Module: event_led_counter
// PURPOSE
//   Counts external interrupt/strobe events from an asynchronous board input and drives the
//   count onto the board LED bank. Width, synchroniser depth, count mode and overflow policy are
//   parametrised. Sits at the base-design top level between board I/O and the LED pins.
//   Debug/bring-up aid for the FIR datapath.
// PARAMETERS
//   WIDTH        10  counter and LED width in bits (2..32)
//   SYNC_STAGES  2   flops in the input synchroniser (2..4)
//   EDGE_MODE    1   1: count rising edges of synced input; 0: count every cycle input is high
//   SATURATE     0   0: wrap 2^WIDTH-1 -> 0; 1: hold at 2^WIDTH-1
//   STRETCH_CYC  8   activity-LED hold time in cycles (used only with EVT_STRETCH_EN)
// PORTS
//   clk       in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   inter     in   1      asynchronous event input
//   en        in   1      count enable (synchronous to clk)
//   clr       in   1      synchronous clear of counter and overflow flag
//   leds      out  WIDTH  current count
//   ovf       out  1      sticky overflow flag
//   act_led   out  1      activity indicator (present only with EVT_STRETCH_EN)
// BEHAVIOUR
//   Clock/reset: one clock, clk; reset is asynchronous and active-high (rst).
//   Reset values: all sync flops 0, count 0, leds 0, ovf 0, act_led 0. Reset asserted
//     mid-count clears immediately. First event is counted only on a fresh qualifying
//     input after deassertion.
//   Synchroniser: inter passes through SYNC_STAGES flops; sync_q = last stage; prev_q = sync_q
//     delayed 1 cycle.
//   Event: EDGE_MODE=1 -> evt = sync_q & ~prev_q. EDGE_MODE=0 -> evt = sync_q.
//   Latency: inter high sampled at edge k -> leds updated at edge k+SYNC_STAGES.
//   Counter update priority per cycle: clr > (en & evt) > hold.
//     clr: count <= 0, ovf <= 0, regardless of en/evt in the same cycle.
//     en & evt & count < MAX: count <= count + 1.
//     en & evt & count == MAX: SATURATE=0 -> count <= 0; SATURATE=1 -> count holds MAX.
//       In both modes ovf <= 1.
//     en = 0: events are dropped, not queued. Edge history still tracks, so no spurious
//       event occurs when en re-asserts while the input is high.
//   ovf stays set until clr or rst. Further overflows leave it 1.
//   leds is driven directly from the count register; no combinational path from inter.
//   Arithmetic is unsigned, WIDTH bits. MAX = {WIDTH{1'b1}}; no WIDTH+1 compare.
// CONFIGURATION
//   EVT_STRETCH_EN defined:
//     - adds port act_led and a down-counter of $clog2(STRETCH_CYC+1) bits;
//     - each counted event (en & evt, not clr) reloads it to STRETCH_CYC;
//     - act_led = (counter != 0), high for exactly STRETCH_CYC cycles after the last event;
//     - retrigger while running restarts the full period; clr and rst zero it.
//   EVT_STRETCH_EN undefined: act_led port and stretch logic are absent; all else identical.
// STRUCTURE
//   Package event_led_pkg:
//     - typedef enum {CNT_WRAP, CNT_SAT} cnt_mode_e
//     - typedef enum {EVT_LEVEL, EVT_EDGE} evt_mode_e
//     - localparam limits SYNC_MIN=2, SYNC_MAX=4
//   Sub-module sync_edge_det (params SYNC_STAGES, EDGE_MODE; ports clk, rst, d_async, evt):
//     synchroniser plus event qualifier.
//   Top contains the counter, overflow flag and optional stretcher.
//   Elaboration-time $error if WIDTH or SYNC_STAGES is out of range.
// TESTING
//   1. rst=1 mid-count (count=5), then release: leds=0 and ovf=0 asynchronously; no count
//      until a new rising edge arrives.
//   2. Default params, inter high for 20 cycles once: leds=1 at edge k+2.
//      EDGE_MODE=0, same stimulus: leds=20.
//   3. WIDTH=4, SATURATE=0, 17 edges: leds 15 -> 0 on the 16th edge, ovf=1; leds=1 after
//      the 17th. SATURATE=1, same stimulus: leds=15, ovf=1.
//   4. clr and evt in the same cycle with count=7: leds=0, ovf=0 next edge (clr wins).
//      en=0 during 3 edges: count unchanged.
//   5. EVT_STRETCH_EN, STRETCH_CYC=8: single edge -> act_led high for exactly 8 cycles.
//      Second edge at cycle 5 -> act_led stays high until cycle 13.
//   6. Random async inter with en toggling: scoreboard count equals model
//      (sum of en & edge mod 2^WIDTH); no X on outputs.

Source files
------------

// File: rtl/event_led_pkg.sv
// event_led_pkg: shared mode enums and synchroniser depth limits for the event LED counter.
package event_led_pkg;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  typedef enum logic {EVT_LEVEL, EVT_EDGE} evt_mode_e;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an async input plus rising-edge or level event qualifier.
module sync_edge_det import event_led_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic evt
);
  localparam evt_mode_e MODE = (EDGE_MODE != 0) ? EVT_EDGE : EVT_LEVEL;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign evt = (MODE == EVT_EDGE) ? (sync_q[SYNC_STAGES-1] & ~prev_q) : sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/event_led_counter.sv
// event_led_counter: counts synchronised events from an async input onto the LED bank with a sticky overflow flag.
// Optional activity-LED stretcher is built when EVT_STRETCH_EN is defined.
module event_led_counter import event_led_pkg::*; #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int SATURATE    = 0,
  parameter int STRETCH_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inter,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] leds,
  output logic             ovf
`ifdef EVT_STRETCH_EN
  , output logic           act_led
`endif
);
  localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("event_led_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("event_led_counter: SYNC_STAGES %0d outside %0d..%0d", SYNC_STAGES, SYNC_MIN, SYNC_MAX);
  end
  if (STRETCH_CYC < 1) begin : g_bad_stretch
    $error("event_led_counter: STRETCH_CYC must be at least 1");
  end
  logic             evt, hit;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(EDGE_MODE)) u_sync (
    .clk(clk), .rst(rst), .d_async(inter), .evt(evt)
  );
  assign hit = en & evt;
  // clr beats a same-cycle event; a hit at all-ones both overflows and wraps or holds
  always_comb begin
    cnt_d = clr ? '0 : !hit ? cnt_q : (cnt_q != '1) ? cnt_q + 1'b1 : (MODE == CNT_SAT) ? cnt_q : '0;
    ovf_d = !clr & (ovf_q | (hit & (cnt_q == '1)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign leds = cnt_q;
  assign ovf  = ovf_q;
`ifdef EVT_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYC + 1);
  logic [SW-1:0] str_q, str_d;
  always_comb str_d = clr ? '0 : hit ? SW'(STRETCH_CYC) : (str_q != '0) ? str_q - 1'b1 : str_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) str_q <= '0;
    else     str_q <= str_d;
  end
  assign act_led = (str_q != '0);
`endif
endmodule

// File: tb/tb_event_led_counter.sv
// tb_event_led_counter: directed checks of reset, latency, wrap/saturate, clr/en priority, stretcher and a random run.
module tb_event_led_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1, inter = 1'b0, en = 1'b1, clr = 1'b0;
  logic [9:0] leds_d, leds_l;
  logic [3:0] leds_w, leds_s;
  logic       ovf_d, ovf_l, ovf_w, ovf_s;
`ifdef EVT_STRETCH_EN
  logic       act_d, act_l, act_w, act_s;
`endif
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  event_led_counter #(.WIDTH(10)) u_dut (.clk(clk), .rst(rst), .inter(inter), .en(en), .clr(clr),
    .leds(leds_d), .ovf(ovf_d)
`ifdef EVT_STRETCH_EN
    , .act_led(act_d)
`endif
  );
  event_led_counter #(.WIDTH(10), .EDGE_MODE(0)) u_lvl (.clk(clk), .rst(rst), .inter(inter), .en(en), .clr(clr),
    .leds(leds_l), .ovf(ovf_l)
`ifdef EVT_STRETCH_EN
    , .act_led(act_l)
`endif
  );
  event_led_counter #(.WIDTH(4), .SATURATE(0)) u_w4 (.clk(clk), .rst(rst), .inter(inter), .en(en), .clr(clr),
    .leds(leds_w), .ovf(ovf_w)
`ifdef EVT_STRETCH_EN
    , .act_led(act_w)
`endif
  );
  event_led_counter #(.WIDTH(4), .SATURATE(1)) u_w4s (.clk(clk), .rst(rst), .inter(inter), .en(en), .clr(clr),
    .leds(leds_s), .ovf(ovf_s)
`ifdef EVT_STRETCH_EN
    , .act_led(act_s)
`endif
  );
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; inter = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      inter = 1'b1; @(negedge clk);
      inter = 1'b0; @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_reset;
    do_reset;
    vecs++; if (leds_d !== 10'd0 || ovf_d !== 1'b0) begin errs++; $display("FAIL reset_state leds=%0d ovf=%b want 0 0", leds_d, ovf_d); end
    pulses(21);
    vecs++; if (leds_d !== 10'd21) begin errs++; $display("FAIL pre_rst_count got %0d want 21", leds_d); end
    vecs++; if (leds_w !== 4'd5 || ovf_w !== 1'b1) begin errs++; $display("FAIL pre_rst_w4 got %0d/%b want 5/1", leds_w, ovf_w); end
    #2 rst = 1'b1;
    #1;
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL async_rst_leds got %0d want 0", leds_d); end
    vecs++; if (leds_w !== 4'd0 || ovf_w !== 1'b0) begin errs++; $display("FAIL async_rst_w4 got %0d/%b want 0/0", leds_w, ovf_w); end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL post_rst_idle got %0d want 0", leds_d); end
    pulses(1);
    vecs++; if (leds_d !== 10'd1) begin errs++; $display("FAIL post_rst_first got %0d want 1", leds_d); end
  endtask
  task automatic test_latency;
    do_reset;
    inter = 1'b1;
    @(posedge clk); #1;
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL lat_k got %0d want 0", leds_d); end
    @(posedge clk); #1;
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL lat_k1 got %0d want 0", leds_d); end
    @(posedge clk); #1;
    vecs++; if (leds_d !== 10'd1) begin errs++; $display("FAIL lat_k2 got %0d want 1", leds_d); end
    @(negedge clk);
    repeat (17) @(negedge clk);
    inter = 1'b0;
    repeat (5) @(negedge clk);
    vecs++; if (leds_d !== 10'd1 || ovf_d !== 1'b0) begin errs++; $display("FAIL edge_hold got %0d/%b want 1/0", leds_d, ovf_d); end
    vecs++; if (leds_l !== 10'd20) begin errs++; $display("FAIL level_hold got %0d want 20", leds_l); end
  endtask
  task automatic test_wrap_sat;
    do_reset;
    pulses(15);
    vecs++; if (leds_w !== 4'd15 || ovf_w !== 1'b0) begin errs++; $display("FAIL wrap_15 got %0d/%b want 15/0", leds_w, ovf_w); end
    vecs++; if (leds_s !== 4'd15 || ovf_s !== 1'b0) begin errs++; $display("FAIL sat_15 got %0d/%b want 15/0", leds_s, ovf_s); end
    pulses(1);
    vecs++; if (leds_w !== 4'd0 || ovf_w !== 1'b1) begin errs++; $display("FAIL wrap_16 got %0d/%b want 0/1", leds_w, ovf_w); end
    vecs++; if (leds_s !== 4'd15 || ovf_s !== 1'b1) begin errs++; $display("FAIL sat_16 got %0d/%b want 15/1", leds_s, ovf_s); end
    pulses(1);
    vecs++; if (leds_w !== 4'd1 || ovf_w !== 1'b1) begin errs++; $display("FAIL wrap_17 got %0d/%b want 1/1", leds_w, ovf_w); end
    vecs++; if (leds_s !== 4'd15 || ovf_s !== 1'b1) begin errs++; $display("FAIL sat_17 got %0d/%b want 15/1", leds_s, ovf_s); end
    vecs++; if (leds_d !== 10'd17) begin errs++; $display("FAIL wide_17 got %0d want 17", leds_d); end
  endtask
  task automatic test_clr_en;
    do_reset;
    pulses(23);
    vecs++; if (leds_w !== 4'd7 || ovf_w !== 1'b1) begin errs++; $display("FAIL clr_pre got %0d/%b want 7/1", leds_w, ovf_w); end
    inter = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    clr = 1'b1; inter = 1'b0;
    @(negedge clk); clr = 1'b0;
    vecs++; if (leds_w !== 4'd0 || ovf_w !== 1'b0) begin errs++; $display("FAIL clr_wins_w4 got %0d/%b want 0/0", leds_w, ovf_w); end
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL clr_wins got %0d want 0", leds_d); end
    repeat (4) @(negedge clk);
    vecs++; if (leds_d !== 10'd0) begin errs++; $display("FAIL clr_after got %0d want 0", leds_d); end
    pulses(2);
    vecs++; if (leds_d !== 10'd2) begin errs++; $display("FAIL en_pre got %0d want 2", leds_d); end
    en = 1'b0;
    pulses(3);
    en = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if (leds_d !== 10'd2) begin errs++; $display("FAIL en_drop got %0d want 2", leds_d); end
    en = 1'b0; inter = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    vecs++; if (leds_d !== 10'd2) begin errs++; $display("FAIL en_reassert got %0d want 2", leds_d); end
    inter = 1'b0;
    repeat (4) @(negedge clk);
    pulses(1);
    vecs++; if (leds_d !== 10'd3) begin errs++; $display("FAIL en_resume got %0d want 3", leds_d); end
  endtask
`ifdef EVT_STRETCH_EN
  task automatic test_stretch;
    int hi;
    do_reset;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hi += int'(act_d);
      inter = (i == 0);
    end
    vecs++; if (hi !== 8) begin errs++; $display("FAIL stretch_single got %0d cycles want 8", hi); end
    hi = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      hi += int'(act_d);
      inter = (i == 0 || i == 5);
    end
    vecs++; if (hi !== 13) begin errs++; $display("FAIL stretch_retrig got %0d cycles want 13", hi); end
    vecs++; if (act_d !== 1'b0) begin errs++; $display("FAIL stretch_idle got %b want 0", act_d); end
  endtask
`endif
  task automatic test_random;
    logic [9:0] model;
    logic h1, h2, h3, r, e;
    do_reset;
    model = '0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    repeat (300) begin
      r = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      inter = r; en = e;
      @(posedge clk);
      if (e && h2 && !h3) model = model + 10'd1;
      h3 = h2; h2 = h1; h1 = r;
      @(negedge clk);
      vecs++; if (leds_d !== model || $isunknown({leds_d, ovf_d})) begin errs++; $display("FAIL random_count got %0d want %0d", leds_d, model); end
    end
    inter = 1'b0; en = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_latency;
    test_wrap_sat;
    test_clr_en;
`ifdef EVT_STRETCH_EN
    test_stretch;
`endif
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
